// File: rtl/frame_pkg.sv
// Shared types and constants for the ADC frame builder.
package frame_pkg;

    // Header is sync, sequence number and length, ahead of the samples.
    localparam int unsigned HDR_WORDS = 3;

    localparam logic [15:0] DEF_SYNC_WORD     = 16'hA55A;
    localparam logic [15:0] DEF_UNDERRUN_FILL = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        HDR_SYNC,
        HDR_SEQ,
        HDR_LEN,
        RD_REQ,
        RD_WAIT,
        SAMPLE,
        CKSUM
    } state_t;

    // Total words on the wire for a frame of len samples (header + samples + checksum).
    function automatic int unsigned frame_words(input int unsigned len);
        return len + HDR_WORDS + 1;
    endfunction

endpackage

// File: rtl/frame_builder.sv
// Pops one capture from the sample FIFO and emits it as a framed word stream:
// sync, sequence number, length, samples, mod-2^16 checksum of the samples.
//
// Output handshake: a word moves on any cycle where out_valid_o and out_ready_i
// are both high. Once out_valid_o rises, out_data_o holds still and out_valid_o
// stays high until that transfer happens; valid only falls after a transfer.
module frame_builder
    import frame_pkg::*;
#(
    parameter int unsigned     DATA_W        = 16,
    parameter int unsigned     FRAME_LEN     = 100,
    parameter logic [15:0]     SYNC_WORD     = DEF_SYNC_WORD,
    parameter logic [15:0]     UNDERRUN_FILL = DEF_UNDERRUN_FILL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_rd_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o,
    output state_t            state_dbg
);

    // FRAME_LEN is at most 16383, so a 14-bit sample index is enough.
    localparam int unsigned       IDX_W    = 14;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [DATA_W-1:0] LEN_WORD = DATA_W'(FRAME_LEN);

    state_t             state;
    state_t             state_d;
    logic [15:0]        seq;
    logic               seq_inc;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_d;
    logic [DATA_W-1:0]  cksum;
    logic [DATA_W-1:0]  cksum_d;
    logic [DATA_W-1:0]  out_data_d;
    logic               out_valid_d;
    logic               done_d;
    logic               underrun_d;
    logic               xfer;

    assign xfer      = out_valid_o && out_ready_i;
    assign busy_o    = (state != IDLE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, output-register loads and the FIFO pop strobe.
    always_comb begin
        state_d     = state;
        out_data_d  = out_data_o;
        out_valid_d = out_valid_o;
        done_d      = 1'b0;
        underrun_d  = underrun_o;
        idx_d       = idx;
        cksum_d     = cksum;
        seq_inc     = 1'b0;
        fifo_rd_o   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    out_data_d  = DATA_W'(SYNC_WORD);
                    out_valid_d = 1'b1;
                    underrun_d  = 1'b0;
                    idx_d       = '0;
                    cksum_d     = '0;
                    state_d     = HDR_SYNC;
                end
            end
            HDR_SYNC: begin
                if (xfer) begin
                    out_data_d = DATA_W'(seq);
                    state_d    = HDR_SEQ;
                end
            end
            HDR_SEQ: begin
                if (xfer) begin
                    out_data_d = LEN_WORD;
                    state_d    = HDR_LEN;
                end
            end
            HDR_LEN: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    state_d     = RD_REQ;
                end
            end
            RD_REQ: begin
                // An empty FIFO is padded with the fill word rather than stalling.
                if (fifo_empty_i) begin
                    out_data_d  = DATA_W'(UNDERRUN_FILL);
                    out_valid_d = 1'b1;
                    underrun_d  = 1'b1;
                    state_d     = SAMPLE;
                end else begin
                    fifo_rd_o = 1'b1;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                out_data_d  = fifo_data_i;
                out_valid_d = 1'b1;
                state_d     = SAMPLE;
            end
            SAMPLE: begin
                if (xfer) begin
                    cksum_d = cksum + out_data_o;
                    idx_d   = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        out_data_d = cksum_d;
                        state_d    = CKSUM;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = RD_REQ;
                    end
                end
            end
            CKSUM: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    seq_inc     = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Output word, flags, sample index and running checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            done_o      <= 1'b0;
            underrun_o  <= 1'b0;
            idx         <= '0;
            cksum       <= '0;
        end else begin
            out_data_o  <= out_data_d;
            out_valid_o <= out_valid_d;
            done_o      <= done_d;
            underrun_o  <= underrun_d;
            idx         <= idx_d;
            cksum       <= cksum_d;
        end
    end

    // Frame sequence number: advances only when a frame completes, wraps at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq <= '0;
        end else if (seq_inc) begin
            seq <= seq + 16'd1;
        end
    end

endmodule

// File: tb/tb_frame_builder.sv
// Randomized bench for frame_builder with FRAME_LEN=4, a queue-based FIFO model
// and a frame-level reference model feeding an expected-word queue.
module tb_frame_builder;
    import frame_pkg::*;

    localparam int          FL   = 4;
    localparam logic [15:0] SYNC = 16'hA55A;
    localparam logic [15:0] FILL = 16'h8000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic [15:0] fifo_data_i = '0;
    logic        fifo_rd_o;
    logic [15:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        underrun_o;
    state_t      state_dbg;

    always #5 clk = ~clk;

    frame_builder #(
        .DATA_W(16), .FRAME_LEN(FL), .SYNC_WORD(SYNC), .UNDERRUN_FILL(FILL)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_rd_o(fifo_rd_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o), .state_dbg(state_dbg)
    );

    // ---------------- FIFO model ----------------
    logic [15:0] fifo_q[$];

    always @(posedge clk) begin
        if (fifo_rd_o && fifo_q.size() > 0) fifo_data_i <= fifo_q.pop_front();
        fifo_empty_i <= (fifo_q.size() == 0);
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          model_seq = 0;
    int          exp_pops;
    logic        exp_under;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame from the FIFO contents at start time.
    task automatic build_expected();
        int          sum;
        logic [15:0] w;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(SYNC);
        exp_q.push_back(16'(model_seq));
        exp_q.push_back(16'(FL));
        for (int i = 0; i < FL; i++) begin
            w = (i < fifo_q.size()) ? fifo_q[i] : FILL;
            exp_q.push_back(w);
            sum += int'(w);
        end
        exp_q.push_back(16'(sum));
        exp_pops  = (fifo_q.size() < FL) ? fifo_q.size() : FL;
        exp_under = (fifo_q.size() < FL);
    endtask

    // ---------------- driver tasks ----------------
    task automatic fifo_load(input int n, input bit rnd, input int base);
        for (int i = 0; i < n; i++)
            fifo_q.push_back(rnd ? 16'($urandom_range(0, 16'hFFFF)) : 16'(base + i));
        @(negedge clk);
    endtask

    // ready_mode: 0 always ready, 1 ready one cycle in three, 2 random.
    task automatic run_frame(input int ready_mode, input bit extra_start);
        int   pops, dones, busy_gaps, tail, nword;
        bit   done_seen, finished, hold_pend;
        logic [15:0] hold_data;
        pops = 0; dones = 0; busy_gaps = 0; tail = 0; nword = 0;
        done_seen = 0; finished = 0; hold_pend = 0; hold_data = '0;
        build_expected();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            case (ready_mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (cyc % 3 == 2);
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
            start_i = extra_start && (cyc == 1);
            if (hold_pend) begin
                check("valid_held", out_valid_o, 1'b1);
                check("data_stable", out_data_o, hold_data);
            end
            hold_pend = out_valid_o && !out_ready_i;
            hold_data = out_data_o;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) check("extra_word", 1, 0);
                else check($sformatf("word%0d", nword), out_data_o, exp_q.pop_front());
                nword++;
            end
            if (fifo_rd_o) pops++;
            if (done_o) begin
                dones++;
                done_seen = 1;
            end
            if (!done_seen && !busy_o) busy_gaps++;
            if (done_seen) begin
                tail++;
                if (tail > 3) finished = 1;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        out_ready_i = 1'b0;
        if (!done_seen) check("frame_timeout", 0, 1);
        check("words_left", exp_q.size(), 0);
        check("done_count", dones, 1);
        check("pop_count", pops, exp_pops);
        check("busy_gaps", busy_gaps, 0);
        check("busy_after", busy_o, 1'b0);
        check("underrun", underrun_o, exp_under);
        model_seq = (model_seq + 1) % 65536;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", out_data_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_rd", fifo_rd_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_underrun", underrun_o, 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic frame: 1,2,3,4 -> checksum 000A.
        fifo_load(4, 0, 1);
        run_frame(0, 0);
        // Backpressure, ready one in three.
        fifo_load(4, 0, 1);
        run_frame(1, 0);
        // Underrun: only 5,6 available.
        fifo_load(2, 0, 5);
        run_frame(0, 0);
        // Start while busy is ignored.
        fifo_load(4, 1, 0);
        run_frame(0, 1);
        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            fifo_load($urandom_range(0, 6), 1, 0);
            run_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Sequence wrap: preload the counter to FFFF while idle.
        @(negedge clk);
        force dut.seq = 16'hFFFF;
        @(negedge clk);
        release dut.seq;
        model_seq = 16'hFFFF;
        fifo_load(4, 1, 0);
        run_frame(0, 0);
        fifo_load(4, 1, 0);
        run_frame(2, 0);

        // Reset mid-frame while waiting on sample[1].
        fifo_q.delete();
        fifo_load(4, 0, 1);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_rst_state", state_dbg, RD_WAIT);
        #2 rst = 1'b0;
        #1;
        check("arst_data", out_data_o, 0);
        check("arst_valid", out_valid_o, 0);
        check("arst_rd", fifo_rd_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_done", done_o, 0);
        check("arst_underrun", underrun_o, 0);
        check("arst_state", state_dbg, IDLE);
        @(negedge clk);
        out_ready_i = 1'b0;
        rst = 1'b1;
        fifo_q.delete();
        model_seq = 0;
        fifo_load(4, 1, 0);
        run_frame(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_builder.md
Name: frame_builder

Overview:
Downstream stage of the ADC sample FIFO. On a capture-complete pulse it pops exactly FRAME_LEN samples from the FIFO and wraps them into a framed word stream: sync word, sequence number, length, samples, and a 16-bit checksum. The framed words are presented on a valid/ready interface to the SPI word loader. Everything runs in the single clk domain.

Parameters:
DATA_W, 16, sample and output word width
FRAME_LEN, 100, samples per frame (1..16383)
SYNC_WORD, 16'hA55A, first word of every frame
UNDERRUN_FILL, 16'h8000, word substituted when the FIFO is empty at a pop

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle pulse: a full capture is in the FIFO
fifo_empty_i  in  1  FIFO empty flag
fifo_data_i  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_o
fifo_rd_o  out  1  FIFO pop strobe, one cycle per sample
out_data_o  out  DATA_W  framed word to SPI loader
out_valid_o  out  1  out_data_o holds a word
out_ready_i  in  1  SPI loader accepts the word
busy_o  out  1  high from start acceptance until done_o
done_o  out  1  one-cycle pulse after the checksum word is accepted
underrun_o  out  1  high if the last or current frame used UNDERRUN_FILL; cleared at the next start

Behaviour:
- Reset: state IDLE; out_data_o=0, out_valid_o=0, fifo_rd_o=0, busy_o=0, done_o=0, underrun_o=0, seq=0, idx=0, cksum=0. Reset mid-frame abandons the frame. No partial-frame completion.
- Frame order: SYNC_WORD, seq, FRAME_LEN[15:0], sample[0..FRAME_LEN-1], cksum. Total FRAME_LEN+4 words.
- cksum: mod-2^16 sum of the emitted sample words only, including any fill words.
- Handshake: a word transfers on a cycle where out_valid_o and out_ready_i are both high. While valid is high, out_data_o is stable until accepted. Valid never drops without a transfer.
- States:
  IDLE: on start_i, load out_data_o=SYNC_WORD, set out_valid_o=1, busy_o=1, clear underrun_o, idx=0, cksum=0 -> HDR_SYNC. The first word is valid on the cycle after start_i.
  HDR_SYNC: on transfer, present seq -> HDR_SEQ.
  HDR_SEQ: on transfer, present FRAME_LEN -> HDR_LEN.
  HDR_LEN: on transfer, drop valid -> RD_REQ.
  RD_REQ, FIFO not empty: fifo_rd_o=1 for one cycle -> RD_WAIT.
  RD_REQ, FIFO empty: present UNDERRUN_FILL, set valid, set underrun_o -> SAMPLE. No pop.
  RD_WAIT: latch fifo_data_i into out_data_o, set valid -> SAMPLE.
  SAMPLE: on transfer, cksum += out_data_o and idx++. If idx==FRAME_LEN-1, present cksum (including this word) -> CKSUM. Otherwise drop valid -> RD_REQ.
  CKSUM: on transfer, drop valid, pulse done_o, busy_o=0, seq++ -> IDLE.
- seq is 16 bits and wraps 16'hFFFF -> 0. It increments only on a completed frame.
- start_i outside IDLE is ignored and not queued.
- Pop count per frame is at most FRAME_LEN. The block never pops outside RD_REQ.
- Peak throughput is one sample word per 3 cycles with out_ready_i held high.

Decomposition:
- Package frame_pkg: state enum (IDLE, HDR_SYNC, HDR_SEQ, HDR_LEN, RD_REQ, RD_WAIT, SAMPLE, CKSUM), HDR_WORDS=3, default SYNC_WORD, default UNDERRUN_FILL.
- Single module. No sub-module is warranted; the checksum accumulator and output register stay inline.

Test Plan (FRAME_LEN=4 unless noted):
- Basic frame: FIFO holds 1,2,3,4; start_i pulse; out_ready_i=1 -> words A55A,0000,0004,0001,0002,0003,0004,000A; done_o pulses once; fifo_rd_o pulses exactly 4 times; underrun_o=0.
- Backpressure: same data, out_ready_i toggling 1-in-3 -> identical word sequence, no duplicates or drops; out_data_o stable while out_valid_o=1 and out_ready_i=0.
- Underrun: FIFO holds 5,6 only -> samples 0005,0006,8000,8000; cksum 0x000B+0x10000 mod 2^16 = 000B; underrun_o=1; only 2 pops.
- Sequence wrap: force seq to FFFF via 65535 frames (or FRAME_LEN=1 fast loop) -> next frame word1=FFFF, following frame word1=0000.
- Reset mid-frame: deassert rst during the sample[1] wait -> all outputs 0 asynchronously; after release, a new start_i produces word1=0000.
- Start while busy: a second start_i during HDR_SEQ -> ignored; exactly FRAME_LEN+4 words and one done_o.
